// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: one command per byte (optional START, 8-bit write or read, optional STOP).
// SCL is push-pull, SDA is open-drain; every bus phase lasts QTR_CYCLES clk cycles.
module i2c_byte_master #(
  parameter int QTR_CYCLES = 63
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic       cmd_ack,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       ack_err,
  output logic       busy,
  output logic       i2c_scl,
  inout  wire        i2c_sda_io
);

  localparam int CW = $clog2(QTR_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(QTR_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(QTR_CYCLES - 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    dout_q, dout_d;
  logic          rd_q, rd_d, mack_q, mack_d, stop_q, stop_d, rs_q, rs_d;
  logic          dv_q, dv_d, ackerr_q, ackerr_d;
  logic          sda_meta_q, sda_sync_q;
  logic          scl, sda_low, tick, accept, scl_high_phase;

  // Handshake: a command transfers on a posedge where cmd_valid && cmd_ready;
  // cmd_ready is high only while the bus is idle (IDLE) or parked (HOLD).
  assign cmd_ready      = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign busy           = !cmd_ready;
  assign accept         = cmd_valid && cmd_ready;
  assign tick           = (cnt_q == CNT_LAST);
  assign scl_high_phase = phase_q[0] ^ phase_q[1];

  assign i2c_scl    = scl;
  assign i2c_sda_io = sda_low ? 1'b0 : 1'bz;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign ack_err    = ackerr_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      phase_q    <= 2'd0;
      bit_q      <= 3'd0;
      sh_q       <= 8'h00;
      dout_q     <= 8'h00;
      rd_q       <= 1'b0;
      mack_q     <= 1'b0;
      stop_q     <= 1'b0;
      rs_q       <= 1'b0;
      dv_q       <= 1'b0;
      ackerr_q   <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      dout_q     <= dout_d;
      rd_q       <= rd_d;
      mack_q     <= mack_d;
      stop_q     <= stop_d;
      rs_q       <= rs_d;
      dv_q       <= dv_d;
      ackerr_q   <= ackerr_d;
      sda_meta_q <= i2c_sda_io;
      sda_sync_q <= sda_meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    phase_d  = tick ? phase_q + 2'd1 : phase_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    dout_d   = dout_q;
    rd_d     = rd_q;
    mack_d   = mack_q;
    stop_d   = stop_q;
    rs_d     = rs_q;
    dv_d     = 1'b0;
    ackerr_d = ackerr_q;
    scl      = 1'b1;
    sda_low  = 1'b0;
    case (state_q)
      S_IDLE, S_HOLD: begin
        scl     = (state_q == S_IDLE);
        cnt_d   = '0;
        phase_d = 2'd0;
        if (accept) begin
          sh_d     = din;
          rd_d     = cmd_read;
          mack_d   = cmd_ack;
          stop_d   = cmd_stop;
          ackerr_d = 1'b0;
          bit_d    = 3'd0;
          rs_d     = (state_q == S_HOLD) && cmd_start;
          // From IDLE a START is mandatory; from HOLD it is the caller's choice.
          state_d  = (state_q == S_HOLD && !cmd_start) ? S_BIT : S_START;
        end
      end
      S_START: begin
        if (rs_q) begin
          scl     = scl_high_phase;
          sda_low = phase_q[1];
        end else begin
          scl     = (phase_q == 2'd0);
          sda_low = 1'b1;
        end
        if (tick && phase_q == (rs_q ? 2'd3 : 2'd1)) begin
          state_d = S_BIT;
          phase_d = 2'd0;
        end
      end
      S_BIT: begin
        scl     = scl_high_phase;
        sda_low = !rd_q && !sh_q[7];
        if (tick && phase_q == 2'd2 && rd_q) sh_d = {sh_q[6:0], sda_sync_q};
        if (tick && phase_q == 2'd3) begin
          if (!rd_q) sh_d = {sh_q[6:0], 1'b0};
          if (bit_q == 3'd7) state_d = S_ACK;
          bit_d = bit_q + 3'd1;
        end
      end
      S_ACK: begin
        scl     = scl_high_phase;
        sda_low = rd_q && mack_q;
        if (tick && phase_q == 2'd2 && !rd_q) ackerr_d = sda_sync_q;
        // Loaded one cycle early so dout/dout_valid are visible on the last cycle of q3.
        if (phase_q == 2'd3 && cnt_q == CNT_PRE && rd_q) begin
          dout_d = sh_q;
          dv_d   = 1'b1;
        end
        if (tick && phase_q == 2'd3) state_d = stop_q ? S_STOP : S_HOLD;
      end
      S_STOP: begin
        scl     = (phase_q != 2'd0);
        sda_low = !phase_q[1];
        if (tick && phase_q == 2'd3) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: a quarter-phase bus model predicts every cycle of SCL/SDA/status,
// a slave drives SDA from the same timeline, and a monitor collects literal pins per scenario.
module tb_i2c_byte_master;
  localparam int QTR = 4;
  localparam int W   = 13;  // {scl, sda, busy, dout_valid, ack_err, dout[7:0]}

  logic       clk = 1'b0;
  logic       reset_n, cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_ack;
  logic [7:0] din;
  logic       cmd_ready, dout_valid, ack_err, busy, scl;
  logic [7:0] dout;
  logic       slv_low;
  wire        sda;

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_byte_master #(.QTR_CYCLES(QTR)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read), .cmd_ack(cmd_ack),
    .din(din), .dout(dout), .dout_valid(dout_valid), .ack_err(ack_err), .busy(busy),
    .i2c_scl(scl), .i2c_sda_io(sda)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500us");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model state and scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit           slv_q[$];
  string        pin_nm[$];
  logic [15:0]  pin_act[$], pin_exp[$];
  int           n_cmp = 0, n_fail = 0;
  bit           chk_en = 1'b0, rest_idle = 1'b1, m_ae = 1'b0;
  logic [7:0]   m_dout = 8'h00;
  int           mon_busy = 0, mon_dv = 0, mon_rise = 0, mon_start = 0, mon_stop = 0;
  logic [15:0]  mon_cap = 16'h0000;
  logic         prev_scl = 1'b1, prev_sda = 1'b1;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave: applies the planned drive for each cycle just after the clock edge.
  initial begin
    slv_low = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      slv_low = (slv_q.size() > 0) ? slv_q.pop_front() : 1'b0;
    end
  end

  // Compare + monitor, sampled on the falling edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      while (pin_nm.size() > 0) check(pin_nm.pop_front(), pin_act.pop_front(), pin_exp.pop_front());
      if (chk_en) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {rest_idle, 1'b1, 1'b0, 1'b0, m_ae, m_dout};
        check("scl",        16'(scl),        16'(e[12]));
        check("sda",        16'(sda),        16'(e[11]));
        check("busy",       16'(busy),       16'(e[10]));
        check("cmd_ready",  16'(cmd_ready),  16'(!e[10]));
        check("dout_valid", 16'(dout_valid), 16'(e[9]));
        check("ack_err",    16'(ack_err),    16'(e[8]));
        check("dout",       16'(dout),       16'(e[7:0]));
        if (busy) mon_busy++;
        if (dout_valid) mon_dv++;
        if (busy && scl && !prev_scl) begin
          mon_rise++;
          mon_cap = {mon_cap[14:0], sda};
        end
        if (busy && scl && prev_scl && prev_sda && !sda) mon_start++;
        if (busy && scl && prev_scl && !prev_sda && sda) mon_stop++;
        prev_scl = scl;
        prev_sda = sda;
      end
    end
  end

  // ---------------- model: bus timeline per command ----------------
  task automatic push_qtr(input bit s, input bit ml, input bit sl, input bit ae,
                          input bit dvl, input logic [7:0] nd);
    for (int i = 0; i < QTR; i++) begin
      if (dvl && i == QTR - 1) m_dout = nd;
      exp_q.push_back({s, ~(ml | sl), 1'b1, (dvl && i == QTR - 1), ae, m_dout});
      slv_q.push_back(sl);
    end
  endtask

  task automatic model_cmd(input bit st, input bit sp, input bit rd, input bit ak,
                           input logic [7:0] d, input logic [7:0] sb, input bit sack);
    bit ml, sl, nack;
    if (rest_idle) begin
      push_qtr(1, 1, 0, 0, 0, 8'h00);
      push_qtr(0, 1, 0, 0, 0, 8'h00);
    end else if (st) begin
      push_qtr(0, 0, 0, 0, 0, 8'h00);
      push_qtr(1, 0, 0, 0, 0, 8'h00);
      push_qtr(1, 1, 0, 0, 0, 8'h00);
      push_qtr(0, 1, 0, 0, 0, 8'h00);
    end
    for (int i = 7; i >= 0; i--) begin
      ml = rd ? 1'b0 : !d[i];
      sl = rd ? !sb[i] : 1'b0;
      push_qtr(0, ml, sl, 0, 0, 8'h00);
      push_qtr(1, ml, sl, 0, 0, 8'h00);
      push_qtr(1, ml, sl, 0, 0, 8'h00);
      push_qtr(0, ml, sl, 0, 0, 8'h00);
    end
    nack = !rd && !sack;
    ml   = rd && ak;
    sl   = !rd && sack;
    push_qtr(0, ml, sl, 0, 0, 8'h00);
    push_qtr(1, ml, sl, 0, 0, 8'h00);
    push_qtr(1, ml, sl, 0, 0, 8'h00);
    push_qtr(0, ml, sl, nack, rd, sb);
    m_ae = nack;
    if (sp) begin
      push_qtr(0, 1, 0, nack, 0, 8'h00);
      push_qtr(1, 1, 0, nack, 0, 8'h00);
      push_qtr(1, 0, 0, nack, 0, 8'h00);
      push_qtr(1, 0, 0, nack, 0, 8'h00);
    end
    rest_idle = sp;
  endtask

  // ---------------- driver tasks ----------------
  task automatic pin(input string nm, input logic [15:0] act, input logic [15:0] exp);
    pin_nm.push_back(nm);
    pin_act.push_back(act);
    pin_exp.push_back(exp);
  endtask

  task automatic send(input bit st, input bit sp, input bit rd, input bit ak,
                      input logic [7:0] d, input logic [7:0] sb, input bit sack);
    int g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 400) begin
      @(negedge clk);
      g++;
    end
    pin("ready_wait", 16'(cmd_ready), 16'd1);
    cmd_valid = 1'b1; cmd_start = st; cmd_stop = sp; cmd_read = rd; cmd_ack = ak; din = d;
    @(posedge clk);
    model_cmd(st, sp, rd, ak, d, sb, sack);
    #1;
    cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_ack = 1'b0;
    din = $urandom_range(0, 255);
  endtask

  task automatic wait_done();
    int g = 0;
    while (exp_q.size() > 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int b0, r0, s0, p0, v0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
    cmd_read = 1'b0; cmd_ack = 1'b0; din = 8'h00;

    // 1: reset
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pin("rst_scl", 16'(scl), 16'd1);
    pin("rst_sda", 16'(sda), 16'd1);
    pin("rst_ready", 16'(cmd_ready), 16'd1);
    pin("rst_busy", 16'(busy), 16'd0);
    pin("rst_dout", 16'(dout), 16'h00);
    pin("rst_ack_err", 16'(ack_err), 16'd0);
    reset_n = 1'b1;

    // 2: write A5, START+STOP, slave ACKs
    b0 = mon_busy; r0 = mon_rise; s0 = mon_start; p0 = mon_stop;
    send(1, 1, 0, 0, 8'hA5, 8'h00, 1);
    wait_done();
    pin("w_a5_busy_cycles", 16'(mon_busy - b0), 16'd168);
    pin("w_a5_scl_rises", 16'(mon_rise - r0), 16'd10);
    pin("w_a5_bits", mon_cap[9:2], 16'h00A5);
    pin("w_a5_ack_bit", 16'(mon_cap[1]), 16'd0);
    pin("w_a5_starts", 16'(mon_start - s0), 16'd1);
    pin("w_a5_stops", 16'(mon_stop - p0), 16'd1);
    pin("w_a5_ack_err", 16'(ack_err), 16'd0);
    pin("w_a5_idle_scl", 16'(scl), 16'd1);

    // 3: write 34, no STOP, slave NACKs -> HOLD
    send(1, 0, 0, 0, 8'h34, 8'h00, 0);
    wait_done();
    pin("w_34_ack_err", 16'(ack_err), 16'd1);
    pin("w_34_hold_ready", 16'(cmd_ready), 16'd1);
    pin("w_34_hold_scl", 16'(scl), 16'd0);
    pin("w_34_hold_sda", 16'(sda), 16'd1);

    // 4: repeated START read of 3C, master NACK, STOP
    s0 = mon_start; p0 = mon_stop; v0 = mon_dv;
    send(1, 1, 1, 0, 8'h00, 8'h3C, 0);
    wait_done();
    pin("r_3c_dout", 16'(dout), 16'h003C);
    pin("r_3c_dv_pulses", 16'(mon_dv - v0), 16'd1);
    pin("r_3c_rstart", 16'(mon_start - s0), 16'd1);
    pin("r_3c_stops", 16'(mon_stop - p0), 16'd1);
    pin("r_3c_bits", mon_cap[9:2], 16'h003C);
    pin("r_3c_nack_bit", 16'(mon_cap[1]), 16'd1);
    pin("r_3c_ack_err", 16'(ack_err), 16'd0);

    // 5: read with master ACK, then read with STOP
    v0 = mon_dv; s0 = mon_start;
    send(1, 0, 1, 1, 8'h00, 8'h96, 0);
    wait_done();
    pin("r_96_ack_low", 16'(mon_cap[0]), 16'd0);
    pin("r_96_dout", 16'(dout), 16'h0096);
    send(0, 1, 1, 0, 8'h00, 8'h5A, 0);
    wait_done();
    pin("r_5a_dout", 16'(dout), 16'h005A);
    pin("r_5a_bits", mon_cap[9:2], 16'h005A);
    pin("r2_dv_pulses", 16'(mon_dv - v0), 16'd2);
    pin("r2_starts", 16'(mon_start - s0), 16'd1);

    // 6: reset during bit 4 of a write, then a clean write
    send(1, 1, 0, 0, 8'hC3, 8'h00, 1);
    repeat ((2 + 4 * 4 + 1) * QTR) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    exp_q.delete();
    slv_q.delete();
    rest_idle = 1'b1; m_ae = 1'b0; m_dout = 8'h00;
    @(negedge clk);
    pin("mid_rst_scl", 16'(scl), 16'd1);
    pin("mid_rst_sda", 16'(sda), 16'd1);
    pin("mid_rst_busy", 16'(busy), 16'd0);
    reset_n = 1'b1;
    send(1, 1, 0, 0, 8'h81, 8'h00, 1);
    wait_done();
    pin("w_81_bits", mon_cap[9:2], 16'h0081);
    pin("w_81_ack_err", 16'(ack_err), 16'd0);
    pin("w_81_idle_ready", 16'(cmd_ready), 16'd1);

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
